// File: rtl/histeq_frame_sequencer.sv
// Histogram equalizer frame phase controller: clear, input, CDF, output.
// Owns the shared m2 port and hands it to whichever stage is active.
module histeq_frame_sequencer #(
    parameter int           NUM_BINS   = 256,
    parameter logic [127:0] CLEAR_WORD = 128'h0
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         frame_start,
    output logic         frame_busy,
    output logic         frame_done,
    output logic         base_offset,
    output logic         ip_start,
    input  logic         ip_done,
    input  logic [15:0]  ip_m2ReadAddr,
    input  logic [15:0]  ip_m2WriteAddr,
    input  logic [127:0] ip_m2WriteBus,
    input  logic         ip_m2WE,
    output logic         cdf_start,
    input  logic         cdf_done,
    input  logic [15:0]  cdf_m2ReadAddr,
    input  logic [15:0]  cdf_m2WriteAddr,
    input  logic [127:0] cdf_m2WriteBus,
    input  logic         cdf_m2WE,
    output logic         out_start,
    input  logic         out_done,
    output logic [15:0]  m2ReadAddr,
    output logic [15:0]  m2WriteAddr,
    output logic [127:0] m2WriteBus,
    output logic         m2WE
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, INPUT, CDF, OUTPUT, DONE
    } state_t;

    localparam logic [15:0] LAST_BIN = 16'(NUM_BINS - 1);

    state_t      state;
    logic [15:0] clr_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            base_offset <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start) state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_cnt == LAST_BIN) begin
                        clr_cnt <= '0;
                        state   <= INPUT;
                    end else begin
                        clr_cnt <= clr_cnt + 16'd1;
                    end
                end
                INPUT: begin
                    if (ip_done) state <= CDF;
                end
                CDF: begin
                    if (cdf_done) state <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_done) state <= DONE;
                end
                DONE: begin
                    base_offset <= ~base_offset;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Starts and done are decodes of the state register, so reset drops them at once.
    assign frame_busy = (state != IDLE);
    assign frame_done = (state == DONE);
    assign ip_start   = (state == INPUT);
    assign cdf_start  = (state == CDF);
    assign out_start  = (state == OUTPUT);

    always_comb begin
        m2ReadAddr  = '0;
        m2WriteAddr = '0;
        m2WriteBus  = '0;
        m2WE        = 1'b0;
        unique case (state)
            CLEAR: begin
                m2WriteAddr = clr_cnt;
                m2WriteBus  = CLEAR_WORD;
                m2WE        = 1'b1;
            end
            INPUT: begin
                m2ReadAddr  = ip_m2ReadAddr;
                m2WriteAddr = ip_m2WriteAddr;
                m2WriteBus  = ip_m2WriteBus;
                m2WE        = ip_m2WE;
            end
            CDF: begin
                m2ReadAddr  = cdf_m2ReadAddr;
                m2WriteAddr = cdf_m2WriteAddr;
                m2WriteBus  = cdf_m2WriteBus;
                m2WE        = cdf_m2WE;
            end
            default: begin
                m2WE = 1'b0;
            end
        endcase
    end

endmodule
